// File: rtl/sreg_pkg.sv
// Shared constants and FSM state encoding for the shift-register readout/config controller.
package sreg_pkg;

    localparam int SREG_W = 42;
    localparam int LANE_W = SREG_W / 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        READ   = 3'd2,
        PVALID = 3'd3,
        CFG    = 3'd4
    } rdctl_state_t;

endpackage

// File: rtl/sreg_lane_deser.sv
// Serial-in/parallel-out lane register; exposes the post-shift value so the
// owner can capture a complete word on the same edge as the last sample.
module sreg_lane_deser #(
    parameter int LANE_W = 21
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              din,
    output logic [LANE_W-1:0] lane_next
);

    logic [LANE_W-1:0] lane_r;

    assign lane_next = {lane_r[LANE_W-2:0], din};

    // Shift one tap sample in per enabled edge, MSB first.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            lane_r <= '0;
        end else if (en) begin
            lane_r <= lane_next;
        end else begin
            lane_r <= lane_r;
        end
    end

endmodule

// File: rtl/sreg_readout_ctrl.sv
// Drives shift/serial_in/write_cfg of the 42-bit pixel/config shift register,
// deserializing its two taps into a pixel word and serializing config words in.
module sreg_readout_ctrl
    import sreg_pkg::*;
#(
    parameter int SREG_W = 42
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [SREG_W-1:0] cfg_data,
    input  logic [1:0]        sreg_tap,
    output logic              shift_o,
    output logic              serial_o,
    output logic              write_cfg_o,
    output logic [SREG_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              busy
);

    localparam int LANE_W = SREG_W / 2;
    localparam int CNT_W  = $clog2(SREG_W);
    localparam logic [CNT_W-1:0] LANE_LAST = CNT_W'(LANE_W - 1);
    localparam logic [CNT_W-1:0] SREG_LAST = CNT_W'(SREG_W - 1);

    rdctl_state_t      state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic [CNT_W-1:0]  cfg_idx_s;
    logic              cfg_bit_s;
    logic [SREG_W-1:0] shadow_r;
    logic [LANE_W-1:0] upper_next_s;
    logic [LANE_W-1:0] lower_next_s;
    logic              lane_en_s;

    assign cfg_ready = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign lane_en_s = (state_r == READ);

    sreg_lane_deser #(.LANE_W(LANE_W)) u_upper (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .en        (lane_en_s),
        .din       (sreg_tap[1]),
        .lane_next (upper_next_s)
    );

    sreg_lane_deser #(.LANE_W(LANE_W)) u_lower (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .en        (lane_en_s),
        .din       (sreg_tap[0]),
        .lane_next (lower_next_s)
    );

    // Next config bit to present: the one following the bit currently on serial_o.
    always_comb begin
        cnt_next_s = cnt_r + CNT_W'(1);
        cfg_idx_s  = CNT_W'(SREG_W - 2) - cnt_r;
        if (cnt_r < SREG_LAST) begin
            cfg_bit_s = shadow_r[cfg_idx_s];
        end else begin
            cfg_bit_s = 1'b0;
        end
    end

    // Control FSM; outputs are set for the state being entered so they are glitch-free.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            shift_o     <= 1'b0;
            serial_o    <= 1'b0;
            write_cfg_o <= 1'b0;
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            shadow_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r       <= '0;
                    write_cfg_o <= 1'b0;
                    if (cfg_valid) begin
                        shadow_r <= cfg_data;
                        shift_o  <= 1'b1;
                        serial_o <= cfg_data[SREG_W-1];
                        state_r  <= CFG;
                    end else if (rd_req) begin
                        shift_o  <= 1'b0;
                        serial_o <= 1'b0;
                        state_r  <= LOAD;
                    end else begin
                        shift_o  <= 1'b0;
                        serial_o <= 1'b0;
                    end
                end
                LOAD: begin
                    cnt_r    <= '0;
                    shift_o  <= 1'b1;
                    serial_o <= 1'b0;
                    state_r  <= READ;
                end
                READ: begin
                    if (cnt_r == LANE_LAST) begin
                        cnt_r     <= '0;
                        shift_o   <= 1'b0;
                        pix_data  <= {upper_next_s, lower_next_s};
                        pix_valid <= 1'b1;
                        state_r   <= PVALID;
                    end else begin
                        cnt_r <= cnt_next_s;
                    end
                end
                PVALID: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        cnt_r     <= '0;
                        state_r   <= IDLE;
                    end else begin
                        pix_valid <= 1'b1;
                    end
                end
                CFG: begin
                    if (cnt_r == SREG_LAST) begin
                        cnt_r       <= '0;
                        shift_o     <= 1'b0;
                        serial_o    <= 1'b0;
                        write_cfg_o <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        cnt_r       <= cnt_next_s;
                        serial_o    <= cfg_bit_s;
                        write_cfg_o <= (cnt_next_s == SREG_LAST);
                    end
                end
                default: begin
                    cnt_r       <= '0;
                    shift_o     <= 1'b0;
                    serial_o    <= 1'b0;
                    write_cfg_o <= 1'b0;
                    pix_valid   <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule
